// File: rtl/mac_accum_sequencer_pkg.sv
// mac_accum_sequencer_pkg: shared MAC widths, saturation constants and tree_sum decode
package mac_accum_sequencer_pkg;
  localparam int LANES = 9;
  localparam int OP_W = 8;
  localparam int BIAS_W = 16;
  localparam int TREE_W = 14;
  localparam int RES_W = 13;
  localparam int PASS_W = 4;
  localparam logic [RES_W-1:0] SAT_POS = 13'h0FFF;
  localparam logic [RES_W-1:0] SAT_NEG = 13'h1000;
  typedef struct packed {
    logic [RES_W-1:0] val;
    logic sat;
  } dec_t;
  function automatic dec_t sat_decode(input logic [TREE_W-1:0] s);
    dec_t d;
    d.sat = s[TREE_W-1] ^ s[TREE_W-2];
    d.val = !d.sat ? s[RES_W-1:0] : s[TREE_W-1] ? SAT_NEG : SAT_POS;
    return d;
  endfunction
endpackage

// File: rtl/tree_sat_decode.sv
// tree_sat_decode: maps the guarded 14-bit tree sum onto a saturated 13-bit value
module tree_sat_decode
  import mac_accum_sequencer_pkg::*;
(
  input  logic [TREE_W-1:0] tree_sum,
  output logic [RES_W-1:0]  value,
  output logic              sat
);
  assign {value, sat} = sat_decode(tree_sum);
endmodule

// File: rtl/mac_accum_sequencer.sv
// mac_accum_sequencer: issues operand beats to the MAC tree and accumulates PASSES beats per result
module mac_accum_sequencer
  import mac_accum_sequencer_pkg::*;
#(
  parameter int PASSES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*OP_W-1:0]  in_act,
  input  logic [LANES*OP_W-1:0]  in_wgt,
  input  logic [BIAS_W-1:0]      in_bias,
  input  logic                   clear,
  output logic [LANES*OP_W-1:0]  tree_act,
  output logic [LANES*OP_W-1:0]  tree_wgt,
  output logic [BIAS_W-1:0]      tree_bias,
  output logic [RES_W-1:0]       tree_pre,
  input  logic [TREE_W-1:0]      tree_sum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RES_W-1:0]       out_data,
  output logic                   out_sat,
  output logic [PASS_W-1:0]      pass_idx
);
  localparam logic [PASS_W-1:0] LAST = PASS_W'(PASSES - 1);
  logic op_valid_q, op_valid_d;
  logic [LANES*OP_W-1:0] act_q, act_d, wgt_q, wgt_d;
  logic [BIAS_W-1:0] bias_q, bias_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [RES_W-1:0] acc_q, acc_d, out_data_q, out_data_d, dec_val;
  logic sat_acc_q, sat_acc_d, out_valid_q, out_valid_d, out_sat_q, out_sat_d;
  logic dec_sat, last, advance, accept, retire, emit;
  tree_sat_decode u_dec (
    .tree_sum (tree_sum),
    .value    (dec_val),
    .sat      (dec_sat)
  );
  // a last-pass beat may only retire once the previous result has a free slot
  always_comb begin
    last = pass_q == LAST;
    advance = !(last && out_valid_q && !out_ready);
    in_ready = !clear && (!op_valid_q || advance);
    accept = in_valid && in_ready;
    retire = op_valid_q && advance && !clear;
    emit = retire && last;
    op_valid_d = !clear && (accept || (op_valid_q && !retire));
    act_d = accept ? in_act : act_q;
    wgt_d = accept ? in_wgt : wgt_q;
    bias_d = accept ? in_bias : bias_q;
    pass_d = clear ? '0 : retire ? (last ? '0 : pass_q + 1'b1) : pass_q;
    acc_d = clear ? '0 : (retire && !last) ? dec_val : acc_q;
    sat_acc_d = clear ? 1'b0 : retire ? (!last && (sat_acc_q || dec_sat)) : sat_acc_q;
    out_valid_d = emit || (out_valid_q && !out_ready);
    out_data_d = emit ? dec_val : out_data_q;
    out_sat_d = emit ? (sat_acc_q || dec_sat) : out_sat_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      op_valid_q <= 1'b0;
      act_q <= '0;
      wgt_q <= '0;
      bias_q <= '0;
      pass_q <= '0;
      acc_q <= '0;
      sat_acc_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      op_valid_q <= op_valid_d;
      act_q <= act_d;
      wgt_q <= wgt_d;
      bias_q <= bias_d;
      pass_q <= pass_d;
      acc_q <= acc_d;
      sat_acc_q <= sat_acc_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_sat_q <= out_sat_d;
    end
  assign tree_act = act_q;
  assign tree_wgt = wgt_q;
  assign tree_bias = pass_q == '0 ? bias_q : '0;
  assign tree_pre = pass_q == '0 ? '0 : acc_q;
  assign pass_idx = pass_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_sat = out_sat_q;
endmodule

// File: tb/tb_mac_accum_sequencer.sv
// tb_mac_accum_sequencer: directed and random scoreboard bench for mac_accum_sequencer
module tb_mac_accum_sequencer;
  localparam int PASSES = 4;
  logic clk = 0, reset = 0;
  logic in_valid = 0, in_ready, clear = 0, out_valid, out_ready = 1, out_sat;
  logic [71:0] in_act = '0, in_wgt = '0, tree_act, tree_wgt;
  logic [15:0] in_bias = '0, tree_bias;
  logic [12:0] tree_pre, out_data;
  logic [13:0] tree_sum;
  logic [3:0] pass_idx;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  mac_accum_sequencer #(.PASSES(PASSES)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt), .in_bias(in_bias), .clear(clear),
    .tree_act(tree_act), .tree_wgt(tree_wgt), .tree_bias(tree_bias),
    .tree_pre(tree_pre), .tree_sum(tree_sum), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .pass_idx(pass_idx)
  );
  // multiplier + adder tree: (sum of products + bias) scaled by 1/64, plus feedback, 14-bit wrap
  int tree_s;
  always_comb begin
    tree_s = int'($signed(tree_bias));
    for (int i = 0; i < 9; i++)
      tree_s = tree_s + int'($signed(tree_act[8*i +: 8])) * int'($signed(tree_wgt[8*i +: 8]));
    tree_s = (tree_s >>> 6) + int'($signed(tree_pre));
    tree_sum = tree_s[13:0];
  end
  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  typedef struct { logic [12:0] data; logic sat; } res_t;
  res_t exp_q[$];
  int m_pass = 0, m_acc = 0;
  bit m_sat = 0;
  task automatic model_flush();
    m_pass = 0; m_acc = 0; m_sat = 0;
  endtask
  // reference: each group is a clamped running sum; bias only counts on the first beat
  task automatic model_beat(input logic [71:0] a, input logic [71:0] w, input logic [15:0] b);
    int p, v;
    p = 0;
    for (int i = 0; i < 9; i++)
      p += int'($signed(a[8*i +: 8])) * int'($signed(w[8*i +: 8]));
    v = ((p + (m_pass == 0 ? int'($signed(b)) : 0)) >>> 6) + (m_pass == 0 ? 0 : m_acc);
    if (v > 4095) begin v = 4095; m_sat = 1; end
    if (v < -4096) begin v = -4096; m_sat = 1; end
    if (m_pass == PASSES - 1) begin
      exp_q.push_back('{13'(v), m_sat});
      model_flush();
    end else begin
      m_acc = v;
      m_pass++;
    end
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic send(input logic [71:0] a, input logic [71:0] w, input logic [15:0] b);
    int n;
    logic [3:0] e_pass;
    logic [12:0] e_pre;
    logic [15:0] e_bias;
    in_act = a; in_wgt = w; in_bias = b; in_valid = 1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      check("accept_timeout", 72'(in_ready), 72'(1));
      in_valid = 0;
      return;
    end
    e_pass = 4'(m_pass);
    e_pre = m_pass == 0 ? 13'd0 : 13'(m_acc);
    e_bias = m_pass == 0 ? b : 16'd0;
    model_beat(a, w, b);
    @(posedge clk); #1;
    in_valid = 0;
    check("issue_act", tree_act, a);
    check("issue_pass_idx", 72'(pass_idx), 72'(e_pass));
    check("issue_tree_pre", 72'(tree_pre), 72'(e_pre));
    check("issue_tree_bias", 72'(tree_bias), 72'(e_bias));
  endtask
  task automatic group(input logic [7:0] a, input logic [7:0] w, input logic [15:0] b, input int n);
    for (int i = 0; i < n; i++) send({9{a}}, {9{w}}, b);
  endtask
  task automatic do_clear();
    clear = 1;
    @(negedge clk);
    check("clear_in_ready", 72'(in_ready), 72'(0));
    @(posedge clk); #1;
    clear = 0;
    model_flush();
    check("clear_pass_idx", 72'(pass_idx), 72'(0));
  endtask
  bit rnd_ready = 0;
  task automatic drain();
    int n;
    rnd_ready = 0;
    out_ready = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
    check("drain_empty", 72'(exp_q.size()), 72'(0));
    tick();
  endtask
  initial forever begin
    @(posedge clk); #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end
  res_t mon_e;
  logic [12:0] hold_data;
  logic hold_sat, hold_chk = 0;
  always @(negedge clk) begin
    if (!reset) hold_chk = 0;
    else begin
      if (hold_chk) begin
        check("hold_valid", 72'(out_valid), 72'(1));
        check("hold_data", 72'(out_data), 72'(hold_data));
        check("hold_sat", 72'(out_sat), 72'(hold_sat));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 72'(out_data), 72'(13'h1fff) + 72'(1));
        else begin
          mon_e = exp_q.pop_front();
          check("out_data", 72'(out_data), 72'(mon_e.data));
          check("out_sat", 72'(out_sat), 72'(mon_e.sat));
        end
      end
      hold_chk = out_valid && !out_ready;
      hold_data = out_data;
      hold_sat = out_sat;
    end
  end
  logic [71:0] r_a, r_w;
  logic [15:0] r_b;
  initial begin
    #3;
    check("rst_out_valid", 72'(out_valid), 72'(0));
    check("rst_tree_act", tree_act, 72'(0));
    check("rst_pass_idx", 72'(pass_idx), 72'(0));
    check("rst_tree_pre", 72'(tree_pre), 72'(0));
    check("rst_in_ready", 72'(in_ready), 72'(1));
    repeat (2) @(posedge clk);
    #2 reset = 1;
    tick();
    group(8'd64, 8'd64, 16'd0, 3);
    send({9{8'd64}}, {9{8'd64}}, 16'd0);
    check("latency_before", 72'(out_valid), 72'(0));
    tick();
    check("latency_valid", 72'(out_valid), 72'(1));
    drain();
    group(8'd127, 8'd127, 16'd0, 4);
    drain();
    group(8'h80, 8'd127, 16'd0, 4);
    drain();
    out_ready = 0;
    group(8'd64, 8'd64, 16'd0, 8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 72'(in_ready), 72'(0));
      check("bp_pass_idx", 72'(pass_idx), 72'(PASSES - 1));
    end
    tick();
    out_ready = 1;
    drain();
    group(8'd0, 8'd0, 16'sd640, 4);
    drain();
    group(8'd64, 8'd64, 16'd0, 2);
    do_clear();
    group(8'd64, 8'd64, 16'd0, 4);
    drain();
    group(8'd64, 8'd64, 16'd0, 2);
    #2 reset = 0;
    #1;
    check("mid_rst_tree_act", tree_act, 72'(0));
    check("mid_rst_tree_wgt", tree_wgt, 72'(0));
    check("mid_rst_tree_bias", 72'(tree_bias), 72'(0));
    check("mid_rst_tree_pre", 72'(tree_pre), 72'(0));
    check("mid_rst_pass_idx", 72'(pass_idx), 72'(0));
    check("mid_rst_out_valid", 72'(out_valid), 72'(0));
    check("mid_rst_out_data", 72'(out_data), 72'(0));
    check("mid_rst_out_sat", 72'(out_sat), 72'(0));
    @(posedge clk);
    #2 reset = 1;
    model_flush();
    tick();
    group(8'd64, 8'd64, 16'd0, 4);
    drain();
    rnd_ready = 1;
    for (int g = 0; g < 16; g++)
      for (int b = 0; b < PASSES; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        for (int i = 0; i < 9; i++) begin
          r_a[8*i +: 8] = 8'($urandom);
          r_w[8*i +: 8] = 8'($urandom);
        end
        r_b = 16'($urandom);
        send(r_a, r_w, r_b);
        if (m_pass != 0 && $urandom_range(0, 9) == 0) do_clear();
      end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mac_accum_sequencer.md
Name: mac_accum_sequencer

Overview:
- Drives one 9-lane multiplier / adder-tree MAC datapath from the issue side, and closes the accumulation loop from the result side.
- Accepts 9-pair operand beats over a valid/ready handshake and presents them registered to the multiplier and the tree.
- Feeds the decoded, saturated 13-bit partial sum back as `pre_output` for PASSES consecutive beats, then emits one finished 13-bit result over a valid/ready handshake.
- Sits between the operand buffer and the output/activation stage.

Parameters:
- PASSES, 4, beats accumulated per output (pass 0 has zero feedback). Legal range is 1..15.
- LANES, 9, multiplier lanes per beat. This is fixed to match the tree.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid&in_ready
- in_act  in  72  9 signed 8-bit multiplicands, lane 0 in [7:0]
- in_wgt  in  72  9 signed 8-bit multipliers
- in_bias  in  16  signed bias; used only on the pass-0 beat
- clear  in  1  synchronous flush of the in-flight accumulation
- tree_act  out  72  registered multiplicands to the multiplier
- tree_wgt  out  72  registered multipliers to the multiplier
- tree_bias  out  16  bias to tree stage 1; zero on passes 1..PASSES-1
- tree_pre  out  13  signed feedback to tree stage 2
- tree_sum  in  14  final-adder output; [13:12] are saturation guard bits
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid&out_ready
- out_data  out  13  signed saturated result
- out_sat  out  1  result saturated on at least one pass
- pass_idx  out  4  pass number of the beat currently in the issue register

Behaviour:
- Reset (reset=0, asynchronous) clears the following to 0: op_valid, tree_act, tree_wgt, tree_bias, tree_pre, pass_idx, acc_q, out_valid, out_data, out_sat.
- Issue register:
  - On in_valid&in_ready, capture in_act, in_wgt and bias into the issue register and set op_valid.
  - tree_bias = in_bias when the captured pass is 0, else 0.
  - The tree is combinational, so tree_sum is valid in the same cycle as the issue register.
- Decode of tree_sum:
  - [13:12]=01 → 13'h0FFF, with a sat flag.
  - [13:12]=10 → 13'h1000, with a sat flag.
  - Otherwise → tree_sum[12:0].
- Feedback: tree_pre = 0 when pass_idx==0, else acc_q.
- Retire: on a clock edge with op_valid and advance:
  - Not the last pass (pass_idx<PASSES-1): acc_q ← decoded; pass_idx+1; sat_acc |= sat.
  - Last pass: out_data ← decoded; out_sat ← sat_acc|sat; out_valid←1; pass_idx←0; sat_acc←0.
  - In both cases, op_valid ← in_valid&in_ready. The next beat is loaded in the same edge.
- advance = !(pass_idx==PASSES-1 && out_valid && !out_ready).
- in_ready = !op_valid || advance. This gives 1 beat/cycle throughput with no bubbles.
- Output handshake:
  - out_valid clears on out_ready unless a new last-pass retire occurs in the same edge; in that case out_data is replaced and out_valid stays 1.
  - out_data and out_sat hold stable while out_valid&!out_ready.
- Latency: the last beat is accepted at edge N and out_valid rises at edge N+1.
- clear: synchronous. It sets op_valid←0, pass_idx←0, acc_q←0, sat_acc←0. in_ready=0 during the clear cycle. A pending out_valid is untouched.
- Sequencing rules:
  - PASSES==1: every beat produces a result with tree_pre=0.
  - No pass restarts mid-group.
  - Reset mid-group discards the partial sum.
  - pass_idx wraps only via the last-pass retire path.

Decomposition:
- Shared package (used with the multiplier and the tree):
  - Constants: LANES=9, operand width 8, bias width 16, tree output width 14, result width 13.
  - Saturation constants 13'h0FFF / 13'h1000.
- Natural sub-module: tree_sat_decode. It is combinational: 14-bit tree_sum → 13-bit value + sat flag. It is reused by the final stage and by benches.

Test Plan:
- Nominal accumulation: act=64, wgt=64 all lanes, bias=0, 4 beats back-to-back with out_ready=1.
  - Per-pass decoded sums are 576, 1152, 1728.
  - out_data=2304, out_sat=0, out_valid one cycle after beat 4.
- Positive saturation: act=127, wgt=127, 4 beats.
  - Pass 0 gives 2268; pass 1 saturates.
  - out_data=13'h0FFF, out_sat=1.
- Negative saturation: act=-128, wgt=127, 4 beats.
  - Pass 0 gives -2286.
  - out_data=13'h1000 (-4096), out_sat=1.
- Backpressure: 8 beats of act=wgt=64, out_ready=0 until after the first result.
  - in_ready drops while beat 8 sits in the issue register.
  - First result 2304 holds stable; the second result 2304 follows after out_ready=1.
  - No beat is lost or duplicated.
- Bias and feedback gating: bias=16'sd640, act=wgt=0, 4 beats.
  - tree_bias is nonzero only on pass 0.
  - tree_pre = 0,10,10,10.
  - out_data=10.
- Clear and reset mid-group: after 2 beats assert clear, then send 4 beats of act=wgt=64.
  - Result is 2304, not 3456.
  - Repeat with reset low for 1 cycle at beat 2: all outputs read 0 immediately, then the next group yields 2304.
